// File: rtl/mem_resp_demux.sv
// Memory response demultiplexer: steers one response stream from the memory
// arbiter to the instruction cache (port 0) or the data cache (port 1).
// Each port has its own 2-entry FIFO so a stalled consumer never drops data
// and a ready consumer sustains one transfer per cycle.
module mem_resp_demux #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_sel,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out0_valid,
   output logic [ADDR_W-1:0] out0_addr,
   output logic [DATA_W-1:0] out0_data,
   input  logic              out0_ready,
   output logic              out1_valid,
   output logic [ADDR_W-1:0] out1_addr,
   output logic [DATA_W-1:0] out1_data,
   input  logic              out1_ready,
   output logic [1:0]        out0_count,
   output logic [1:0]        out1_count
);

   localparam int PORTS = 2;

   // Per-port views of the FIFO state, gathered so the port logic can be
   // written once inside the generate loop.
   logic [PORTS-1:0] fifo_full;
   logic [PORTS-1:0] fifo_valid;
   logic [PORTS-1:0] push;
   logic [PORTS-1:0] pop;
   logic [PORTS-1:0] consumer_ready;
   logic             accept;
   logic [1:0]        fifo_count [PORTS];
   logic [ADDR_W-1:0] head_addr  [PORTS];
   logic [DATA_W-1:0] head_data  [PORTS];

   assign consumer_ready = {out1_ready, out0_ready};

   // Space is judged on the count at the start of the cycle only; a pop in
   // the same cycle does not make room for a push into a full FIFO.
   assign in_ready = in_sel ? ~fifo_full[1] : ~fifo_full[0];

   // With in_valid low this is 0 even if in_sel is unknown, so no state moves.
   assign accept = in_valid & in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < PORTS; gi++) begin : g_port
         localparam logic PORT_ID = 1'(gi);

         logic [ADDR_W-1:0] addr_mem_reg [DEPTH];
         logic [DATA_W-1:0] data_mem_reg [DEPTH];
         logic              head_ptr_reg;
         logic              tail_ptr_reg;
         logic [1:0]        count_reg;
         logic [1:0]        count_next;

         assign push[gi]       = accept & (in_sel == PORT_ID);
         assign fifo_full[gi]  = (count_reg == 2'(DEPTH));
         assign fifo_valid[gi] = (count_reg != 2'd0);
         // Ready without valid is ignored.
         assign pop[gi]        = fifo_valid[gi] & consumer_ready[gi];

         // Occupancy update; push never happens when full and pop never
         // happens when empty, so the count stays within 0..2.
         always_comb begin
            count_next = count_reg;
            case ({push[gi], pop[gi]})
               2'b10:   count_next = count_reg + 2'd1;
               2'b01:   count_next = count_reg - 2'd1;
               default: count_next = count_reg;
            endcase
         end

         // Payload storage: cleared on reset, tail entry written on push.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  addr_mem_reg[i] <= '0;
                  data_mem_reg[i] <= '0;
               end
            end else if (push[gi]) begin
               addr_mem_reg[tail_ptr_reg] <= in_addr;
               data_mem_reg[tail_ptr_reg] <= in_data;
            end
         end

         // Pointers and count; reset wins over any same-cycle push or pop.
         always_ff @(posedge clk) begin
            if (reset) begin
               head_ptr_reg <= 1'b0;
               tail_ptr_reg <= 1'b0;
               count_reg    <= 2'd0;
            end else begin
               if (push[gi]) begin
                  tail_ptr_reg <= ~tail_ptr_reg;
               end
               if (pop[gi]) begin
                  head_ptr_reg <= ~head_ptr_reg;
               end
               count_reg <= count_next;
            end
         end

         // Head is read straight from the storage registers, so a new entry
         // is only visible the cycle after it was written (no bypass).
         assign head_addr[gi]  = addr_mem_reg[head_ptr_reg];
         assign head_data[gi]  = data_mem_reg[head_ptr_reg];
         assign fifo_count[gi] = count_reg;

         // Occupancy must never exceed the FIFO depth.
         assert property (@(posedge clk) disable iff (reset)
                          count_reg <= 2'(DEPTH));
      end
   endgenerate

   assign out0_valid = fifo_valid[0];
   assign out0_addr  = head_addr[0];
   assign out0_data  = head_data[0];
   assign out0_count = fifo_count[0];

   assign out1_valid = fifo_valid[1];
   assign out1_addr  = head_addr[1];
   assign out1_data  = head_data[1];
   assign out1_count = fifo_count[1];

endmodule

// File: tb/tb_mem_resp_demux.sv
// Testbench for mem_resp_demux: directed vectors drive the input stream, the
// expected responses go into per-port queues as stimulus is issued, and an
// independent monitor pops and compares whenever a port hands over its head.
module tb_mem_resp_demux;

   localparam int DATA_W = 128;
   localparam int ADDR_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } resp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_sel;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out0_valid;
   logic [ADDR_W-1:0] out0_addr;
   logic [DATA_W-1:0] out0_data;
   logic              out0_ready;
   logic              out1_valid;
   logic [ADDR_W-1:0] out1_addr;
   logic [DATA_W-1:0] out1_data;
   logic              out1_ready;
   logic [1:0]        out0_count;
   logic [1:0]        out1_count;

   int checks = 0;
   int errors = 0;

   resp_t q0[$];
   resp_t q1[$];

   mem_resp_demux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_sel     (in_sel),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out0_valid (out0_valid),
      .out0_addr  (out0_addr),
      .out0_data  (out0_data),
      .out0_ready (out0_ready),
      .out1_valid (out1_valid),
      .out1_addr  (out1_addr),
      .out1_data  (out1_data),
      .out1_ready (out1_ready),
      .out0_count (out0_count),
      .out1_count (out1_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, then let the
   // combinational in_ready settle before any checks.
   task automatic drive(input logic rst, input logic v, input logic s,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic r0, input logic r1);
      @(posedge clk);
      #1;
      reset      = rst;
      in_valid   = v;
      in_sel     = s;
      in_addr    = a;
      in_data    = d;
      out0_ready = r0;
      out1_ready = r1;
      if (rst) begin
         q0.delete();
         q1.delete();
      end
      #1;
   endtask

   // Offer a response; exp_rdy is the hand-computed acceptance for this cycle.
   task automatic send(input logic s, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic r0,
                       input logic r1, input logic exp_rdy);
      resp_t r;
      drive(1'b0, 1'b1, s, a, d, r0, r1);
      chk($sformatf("in_ready a=%0h", a), DATA_W'(in_ready), DATA_W'(exp_rdy));
      $display("send sel=%0d addr=%0h data=%0h in_ready=%0d", s, a, d, in_ready);
      if (exp_rdy) begin
         r.addr = a;
         r.data = d;
         if (s) q1.push_back(r);
         else   q0.push_back(r);
      end
   endtask

   task automatic idle(input logic r0, input logic r1);
      drive(1'b0, 1'b0, 1'bx, '0, '0, r0, r1);
   endtask

   // Monitor: each handover (valid & ready before the edge) must match the
   // oldest expected response for that port.
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b0) begin
            if (out0_valid && out0_ready) begin
               if (q0.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL pop0_unexpected got addr %0h required none", out0_addr);
               end else begin
                  e = q0.pop_front();
                  $display("pop0 addr=%0h data=%0h", out0_addr, out0_data);
                  chk("pop0_addr", DATA_W'(out0_addr), DATA_W'(e.addr));
                  chk("pop0_data", out0_data, e.data);
               end
            end
            if (out1_valid && out1_ready) begin
               if (q1.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL pop1_unexpected got addr %0h required none", out1_addr);
               end else begin
                  e = q1.pop_front();
                  $display("pop1 addr=%0h data=%0h", out1_addr, out1_data);
                  chk("pop1_addr", DATA_W'(out1_addr), DATA_W'(e.addr));
                  chk("pop1_data", out1_data, e.data);
               end
            end
         end
      end
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout got running required finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic              prev_sel;
      logic [ADDR_W-1:0] prev_addr;
      logic [ADDR_W-1:0] a;
      logic              s;

      reset      = 1'b1;
      in_valid   = 1'b1;
      in_sel     = 1'b0;
      in_addr    = 32'h999;
      in_data    = 128'h99;
      out0_ready = 1'b0;
      out1_ready = 1'b0;

      // 1: reset for two edges with in_valid high; nothing may be pushed.
      repeat (2) @(posedge clk);
      #2;
      chk("rst_out0_valid", DATA_W'(out0_valid), '0);
      chk("rst_out1_valid", DATA_W'(out1_valid), '0);
      chk("rst_out0_count", DATA_W'(out0_count), '0);
      chk("rst_out1_count", DATA_W'(out1_count), '0);
      chk("rst_out0_addr", DATA_W'(out0_addr), '0);
      idle(1'b0, 1'b0);
      chk("post_rst_count0", DATA_W'(out0_count), '0);

      // 2: first push to port 0 shows up the next cycle.
      send(1'b0, 32'h100, 128'hA, 1'b0, 1'b0, 1'b1);
      chk("first_empty_valid", DATA_W'(out0_valid), '0);
      // 3: second push fills port 0.
      send(1'b0, 32'h140, 128'hB, 1'b0, 1'b0, 1'b1);
      chk("t2_out0_valid", DATA_W'(out0_valid), 1);
      chk("t2_out0_addr", DATA_W'(out0_addr), 128'h100);
      chk("t2_out0_data", out0_data, 128'hA);
      chk("t2_out0_count", DATA_W'(out0_count), 1);
      chk("t2_out1_valid", DATA_W'(out1_valid), '0);
      send(1'b0, 32'h180, 128'hC, 1'b0, 1'b0, 1'b0);
      chk("t3_out0_count", DATA_W'(out0_count), 2);
      send(1'b1, 32'h200, 128'hD, 1'b0, 1'b0, 1'b1);
      chk("t4_out0_count", DATA_W'(out0_count), 2);

      // 4: full port 0 popping this cycle still refuses the push.
      send(1'b0, 32'h180, 128'hC, 1'b1, 1'b0, 1'b0);
      chk("t5_out0_count", DATA_W'(out0_count), 2);
      chk("t5_out1_count", DATA_W'(out1_count), 1);
      chk("t5_out1_addr", DATA_W'(out1_addr), 128'h200);
      send(1'b0, 32'h180, 128'hC, 1'b1, 1'b0, 1'b1);
      chk("t6_out0_count", DATA_W'(out0_count), 1);
      chk("t6_out0_addr", DATA_W'(out0_addr), 128'h140);
      idle(1'b1, 1'b0);
      chk("t7_out0_count", DATA_W'(out0_count), 1);
      chk("t7_out0_addr", DATA_W'(out0_addr), 128'h180);
      idle(1'b1, 1'b1);
      chk("t8_out0_valid", DATA_W'(out0_valid), '0);
      idle(1'b1, 1'b1);
      chk("t9_out1_count", DATA_W'(out1_count), '0);

      // 5: eight back-to-back responses alternating ports, both ready.
      prev_sel  = 1'b0;
      prev_addr = '0;
      for (int i = 0; i < 8; i++) begin
         s = 1'(i);
         a = 32'h400 + 32'(i) * 32'h40;
         send(s, a, 128'h1000 + 128'(i), 1'b1, 1'b1, 1'b1);
         chk("stream_cnt0_le1", DATA_W'(out0_count <= 2'd1), 1);
         chk("stream_cnt1_le1", DATA_W'(out1_count <= 2'd1), 1);
         if (i > 0) begin
            chk("stream_head_valid",
                DATA_W'(prev_sel ? out1_valid : out0_valid), 1);
            chk("stream_head_addr",
                DATA_W'(prev_sel ? out1_addr : out0_addr), DATA_W'(prev_addr));
         end
         prev_sel  = s;
         prev_addr = a;
      end
      idle(1'b1, 1'b1);
      chk("stream_last_addr", DATA_W'(out1_addr), DATA_W'(prev_addr));
      idle(1'b1, 1'b1);
      chk("stream_drain0", DATA_W'(out0_count), '0);
      chk("stream_drain1", DATA_W'(out1_count), '0);

      // 6: reset discards two buffered port 1 entries.
      send(1'b1, 32'h280, 128'hE, 1'b0, 1'b0, 1'b1);
      send(1'b1, 32'h2C0, 128'hF, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      chk("pre_rst_out1_count", DATA_W'(out1_count), 2);
      idle(1'b0, 1'b0);
      chk("mid_rst_out1_count", DATA_W'(out1_count), '0);
      chk("mid_rst_out1_valid", DATA_W'(out1_valid), '0);
      chk("mid_rst_out1_addr", DATA_W'(out1_addr), '0);
      send(1'b1, 32'h300, 128'h30, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b0);
      chk("after_rst_head", DATA_W'(out1_addr), 128'h300);
      chk("after_rst_count", DATA_W'(out1_count), 1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);
      chk("final_count1", DATA_W'(out1_count), '0);

      // Every issued response must have been delivered exactly once.
      chk("q0_drained", DATA_W'(q0.size()), '0);
      chk("q1_drained", DATA_W'(q1.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_resp_demux.md
Name: mem_resp_demux

Overview:
Memory response demultiplexer. It takes a single response stream from the memory arbiter and steers each response to one of two consumers: port 0 is the instruction cache and port 1 is the data cache. It is the return-path counterpart of the 2:1 request select. Each output has a 2-entry FIFO, so one stalled consumer does not lose data and a full-rate stream to a ready consumer sustains one transfer per cycle.

Parameters:
DATA_W, 128, width of response payload (one cache line)
ADDR_W, 32, width of response line address
DEPTH, 2, entries per output FIFO; fixed at 2, and pointer/count widths assume 2

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  response present on input
in_sel  input  1  destination: 0 = port 0 (icache), 1 = port 1 (dcache)
in_addr  input  ADDR_W  response line address
in_data  input  DATA_W  response payload
in_ready  output  1  input accepted this cycle if in_valid and in_ready
out0_valid  output  1  port 0 FIFO head valid
out0_addr  output  ADDR_W  port 0 head address
out0_data  output  DATA_W  port 0 head payload
out0_ready  input  1  port 0 consumer takes head
out1_valid  output  1  port 1 FIFO head valid
out1_addr  output  ADDR_W  port 1 head address
out1_data  output  DATA_W  port 1 head payload
out1_ready  input  1  port 1 consumer takes head
out0_count  output  2  port 0 occupancy (0..2)
out1_count  output  2  port 1 occupancy (0..2)

Behaviour:
- Reset (synchronous, reset=1 at edge):
  - all FIFO pointers and counts go to 0.
  - out*_valid=0, out*_count=0.
  - out*_addr/out*_data=0; payload storage is cleared.
  - Reset has priority over any push or pop in the same cycle.
  - Reset mid-stream discards buffered entries; nothing is replayed.
- in_ready is combinational and equals (in_sel ? out1_count!=2 : out0_count!=2).
  - It depends only on the selected FIFO's count at the start of the cycle.
  - A same-cycle pop does NOT free space for a push when the FIFO is full; the source must retry next cycle.
  - in_ready is driven even when in_valid=0.
- Push: in_valid & in_ready at an edge writes {in_addr,in_data} to the tail of FIFO[in_sel] and advances the tail pointer.
  - The other FIFO is untouched.
- Pop: outN_valid & outN_ready at an edge advances the head of FIFO N.
  - outN_ready while outN_valid=0 has no effect.
- Latency: an accepted response appears on outN_valid/outN_addr/outN_data on the cycle after acceptance when that FIFO was empty; there is no combinational bypass.
- Simultaneous push and pop on the same FIFO (count 1) leaves count at 1, and the new entry becomes head next cycle.
- Both ports may pop in the same cycle independently.
- outN_valid = (outN_count != 0).
  - Head outputs are registered storage reads; they hold stable while valid and not popped.
- Pointers are 1-bit and wrap 1->0. Count is never incremented above 2 or decremented below 0.
- Ordering: per port, strict FIFO order. Across ports there is no ordering guarantee.
- X on in_sel while in_valid=0 must not change state.

Test Plan:
1. Assert reset for 2 cycles with in_valid=1 -> out0_valid=out1_valid=0, counts=0, no push recorded.
2. Push addr 0x100 data 0xA to sel=0 with out0_ready=0 -> next cycle out0_valid=1, out0_addr=0x100, out0_count=1, out1_valid=0.
3. Keep out0_ready=0 and push 0x140, then attempt 0x180 to sel=0 -> count reaches 2, in_ready=0 for 0x180; a push of 0x200 to sel=1 in the same cycle is accepted (in_ready=1).
4. Port 0 full with out0_ready=1 and push to sel=0 -> push rejected; after pop count=1, next-cycle push accepted; heads appear 0x100, 0x140, 0x180 in order.
5. Stream 8 back-to-back responses alternating sel with both ready=1 -> in_ready stays 1, every response appears exactly once on its port one cycle after acceptance, and counts never exceed 1.
6. With port 1 holding 2 entries, assert reset for 1 cycle -> out1_count=0 and out1_valid=0 the next cycle; subsequent push 0x300 emerges as the first port 1 head.
